// File: rtl/tl45_operand_fetch_pkg.sv
// Shared TL45 definitions: ISA widths, opcodes and the operand-fetch buffer layout.
package tl45_pkg;
  localparam int OPC_W    = 5;
  localparam int REG_W    = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  localparam logic [OPC_W-1:0] OP_NOP  = 5'h00;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'h01;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'h02;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'h03;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'h04;
  localparam logic [OPC_W-1:0] OP_OR   = 5'h05;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'h06;
  localparam logic [OPC_W-1:0] OP_AND  = 5'h07;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'h08;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'h09;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'h0A;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'h0B;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'h0C;
  localparam logic [OPC_W-1:0] OP_UMUL = 5'h0D;
  localparam logic [OPC_W-1:0] OP_UDIV = 5'h0E;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  hit;
    data_t val;
  } fwd_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    reg_idx_t         dr;
    logic [3:0]       jmp_cond;
    data_t            sr1_val;
    data_t            sr2_val;
    data_t            target_offset;
    data_t            pc;
    logic             decode_err;
    reg_idx_t         held_sr1;
    reg_idx_t         held_sr2;
  } ibuf_t;
endpackage

// File: rtl/tl45_operand_fetch_if.sv
// Decode-side inputs, forward/writeback buses and ALU-side buffer outputs of the operand-fetch stage.
interface tl45_operand_fetch_if;
  import tl45_pkg::*;

  logic             i_pipe_stall;
  logic             i_pipe_flush;
  logic             o_pipe_stall;
  logic             o_pipe_flush;
  logic [OPC_W-1:0] i_opcode;
  reg_idx_t         i_dr;
  reg_idx_t         i_sr1;
  reg_idx_t         i_sr2;
  logic [3:0]       i_jmp_cond;
  data_t            i_imm;
  logic             i_imm_valid;
  data_t            i_pc;
  logic             i_decode_err;
  reg_idx_t         i_of1_reg;
  data_t            i_of1_val;
  reg_idx_t         i_of2_reg;
  data_t            i_of2_val;
  reg_idx_t         i_wb_reg;
  data_t            i_wb_val;
  logic [OPC_W-1:0] o_opcode;
  reg_idx_t         o_dr;
  logic [3:0]       o_jmp_cond;
  data_t            o_sr1_val;
  data_t            o_sr2_val;
  data_t            o_target_offset;
  data_t            o_pc;
  logic             o_decode_err;

  modport master (
    output i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1, i_sr2, i_jmp_cond,
           i_imm, i_imm_valid, i_pc, i_decode_err, i_of1_reg, i_of1_val,
           i_of2_reg, i_of2_val, i_wb_reg, i_wb_val,
    input  o_pipe_stall, o_pipe_flush, o_opcode, o_dr, o_jmp_cond, o_sr1_val,
           o_sr2_val, o_target_offset, o_pc, o_decode_err
  );

  modport slave (
    input  i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1, i_sr2, i_jmp_cond,
           i_imm, i_imm_valid, i_pc, i_decode_err, i_of1_reg, i_of1_val,
           i_of2_reg, i_of2_val, i_wb_reg, i_wb_val,
    output o_pipe_stall, o_pipe_flush, o_opcode, o_dr, o_jmp_cond, o_sr1_val,
           o_sr2_val, o_target_offset, o_pc, o_decode_err
  );
endinterface

// File: rtl/tl45_regfile.sv
// 16x32 register file: one synchronous write port, two asynchronous reads, r0 hardwired to zero.
module tl45_regfile
  import tl45_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  reg_idx_t wr_reg,
  input  data_t    wr_val,
  input  reg_idx_t rd_reg1,
  output data_t    rd_val1,
  input  reg_idx_t rd_reg2,
  output data_t    rd_val2
);
  data_t mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_reg != '0) begin
      mem[wr_reg] <= wr_val;
    end
  end

  assign rd_val1 = (rd_reg1 == '0) ? '0 : mem[rd_reg1];
  assign rd_val2 = (rd_reg2 == '0) ? '0 : mem[rd_reg2];
endmodule

// File: rtl/tl45_operand_fetch.sv
// TL45 register-read stage: regfile read, of1 > of2 > wb forwarding, and a registered buffer
// that keeps snooping the forward buses while the ALU stalls.
module tl45_operand_fetch
  import tl45_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  tl45_operand_fetch_if.slave bus
);
  ibuf_t ibuf;
  data_t rf_sr1, rf_sr2;
  fwd_t  sr1_fwd, sr2_fwd, held1_fwd, held2_fwd;
  data_t sr1_res, sr2_res;

  tl45_regfile u_rf (
    .clk     (i_clk),
    .reset   (i_reset),
    .wr_reg  (bus.i_wb_reg),
    .wr_val  (bus.i_wb_val),
    .rd_reg1 (bus.i_sr1),
    .rd_val1 (rf_sr1),
    .rd_reg2 (bus.i_sr2),
    .rd_val2 (rf_sr2)
  );

  // Index 0 never hits, which also makes a zero port reg field a non-match.
  function automatic fwd_t fwd_lookup(
    input reg_idx_t idx,
    input reg_idx_t of1_reg, input data_t of1_val,
    input reg_idx_t of2_reg, input data_t of2_val,
    input reg_idx_t wb_reg,  input data_t wb_val
  );
    fwd_t r;
    r = '0;
    if (idx != '0) begin
      if (of1_reg == idx)     r = '{hit: 1'b1, val: of1_val};
      else if (of2_reg == idx) r = '{hit: 1'b1, val: of2_val};
      else if (wb_reg == idx)  r = '{hit: 1'b1, val: wb_val};
    end
    return r;
  endfunction

  always_comb begin
    sr1_fwd   = fwd_lookup(bus.i_sr1, bus.i_of1_reg, bus.i_of1_val, bus.i_of2_reg,
                           bus.i_of2_val, bus.i_wb_reg, bus.i_wb_val);
    sr2_fwd   = fwd_lookup(bus.i_sr2, bus.i_of1_reg, bus.i_of1_val, bus.i_of2_reg,
                           bus.i_of2_val, bus.i_wb_reg, bus.i_wb_val);
    held1_fwd = fwd_lookup(ibuf.held_sr1, bus.i_of1_reg, bus.i_of1_val, bus.i_of2_reg,
                           bus.i_of2_val, bus.i_wb_reg, bus.i_wb_val);
    held2_fwd = fwd_lookup(ibuf.held_sr2, bus.i_of1_reg, bus.i_of1_val, bus.i_of2_reg,
                           bus.i_of2_val, bus.i_wb_reg, bus.i_wb_val);
    sr1_res   = sr1_fwd.hit ? sr1_fwd.val : rf_sr1;
    if (bus.i_imm_valid)  sr2_res = bus.i_imm;
    else if (sr2_fwd.hit) sr2_res = sr2_fwd.val;
    else                  sr2_res = rf_sr2;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_pipe_flush) begin
      ibuf <= '0;
    end else if (bus.i_pipe_stall) begin
      if (held1_fwd.hit) ibuf.sr1_val <= held1_fwd.val;
      if (held2_fwd.hit) ibuf.sr2_val <= held2_fwd.val;
    end else begin
      ibuf.opcode        <= bus.i_opcode;
      ibuf.dr            <= bus.i_dr;
      ibuf.jmp_cond      <= bus.i_jmp_cond;
      ibuf.sr1_val       <= sr1_res;
      ibuf.sr2_val       <= sr2_res;
      ibuf.target_offset <= bus.i_imm;
      ibuf.pc            <= bus.i_pc;
      ibuf.decode_err    <= bus.i_decode_err;
      ibuf.held_sr1      <= bus.i_sr1;
      ibuf.held_sr2      <= bus.i_imm_valid ? '0 : bus.i_sr2;
    end
  end

  assign bus.o_pipe_stall    = bus.i_pipe_stall;
  assign bus.o_pipe_flush    = bus.i_pipe_flush;
  assign bus.o_opcode        = ibuf.opcode;
  assign bus.o_dr            = ibuf.dr;
  assign bus.o_jmp_cond      = ibuf.jmp_cond;
  assign bus.o_sr1_val       = ibuf.sr1_val;
  assign bus.o_sr2_val       = ibuf.sr2_val;
  assign bus.o_target_offset = ibuf.target_offset;
  assign bus.o_pc            = ibuf.pc;
  assign bus.o_decode_err    = ibuf.decode_err;
endmodule

// File: tb/tb_tl45_operand_fetch.sv
// Randomized scoreboard bench for tl45_operand_fetch against an architectural model.
module tb_tl45_operand_fetch;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  tl45_operand_fetch_if bus ();

  tl45_operand_fetch dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opc;
    logic [3:0]  dr;
    logic [3:0]  jc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] off;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_buf;
  int          m_h1, m_h2;
  logic [31:0] m_regs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest in-flight result wins: ALU forward, then memory forward, then writeback.
  function automatic bit bus_value(input int idx, output logic [31:0] v);
    logic [3:0]  r [3];
    logic [31:0] d [3];
    r[0] = bus.i_of1_reg; d[0] = bus.i_of1_val;
    r[1] = bus.i_of2_reg; d[1] = bus.i_of2_val;
    r[2] = bus.i_wb_reg;  d[2] = bus.i_wb_val;
    v = '0;
    if (idx == 0) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (int'(r[k]) == idx) begin
        v = d[k];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [31:0] arch_read(input int idx);
    logic [31:0] v;
    if (idx == 0) return '0;
    if (bus_value(idx, v)) return v;
    return m_regs[idx];
  endfunction

  task automatic model_push();
    logic [31:0] v;
    if (reset) begin
      m_buf = '{default: 0};
      m_h1 = 0;
      m_h2 = 0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
    end else begin
      if (bus.i_pipe_flush) begin
        m_buf = '{default: 0};
        m_h1 = 0;
        m_h2 = 0;
      end else if (bus.i_pipe_stall) begin
        if (bus_value(m_h1, v)) m_buf.s1 = v;
        if (bus_value(m_h2, v)) m_buf.s2 = v;
      end else begin
        m_buf.opc = bus.i_opcode;
        m_buf.dr  = bus.i_dr;
        m_buf.jc  = bus.i_jmp_cond;
        m_buf.s1  = arch_read(int'(bus.i_sr1));
        m_buf.s2  = bus.i_imm_valid ? bus.i_imm : arch_read(int'(bus.i_sr2));
        m_buf.off = bus.i_imm;
        m_buf.pc  = bus.i_pc;
        m_buf.err = bus.i_decode_err;
        m_h1 = int'(bus.i_sr1);
        m_h2 = bus.i_imm_valid ? 0 : int'(bus.i_sr2);
      end
      if (bus.i_wb_reg != 0) m_regs[bus.i_wb_reg] = bus.i_wb_val;
    end
    exp_q.push_back(m_buf);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    chk("stall_passthru", 32'(bus.o_pipe_stall), 32'(bus.i_pipe_stall));
    chk("flush_passthru", 32'(bus.o_pipe_flush), 32'(bus.i_pipe_flush));
    model_push();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    bus.i_pipe_stall = 1'b0; bus.i_pipe_flush = 1'b0;
    bus.i_opcode = '0; bus.i_dr = '0; bus.i_sr1 = '0; bus.i_sr2 = '0;
    bus.i_jmp_cond = '0; bus.i_imm = '0; bus.i_imm_valid = 1'b0;
    bus.i_pc = '0; bus.i_decode_err = 1'b0;
    bus.i_of1_reg = '0; bus.i_of1_val = '0;
    bus.i_of2_reg = '0; bus.i_of2_val = '0;
    bus.i_wb_reg = '0;  bus.i_wb_val = '0;
  endtask

  task automatic issue(input logic [4:0] opc, input logic [3:0] dr, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [31:0] pc);
    bus.i_opcode = opc; bus.i_dr = dr; bus.i_sr1 = s1; bus.i_sr2 = s2; bus.i_pc = pc;
  endtask

  // Monitor: every cycle the buffer presents a new state, compare it to the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("opcode",        32'(bus.o_opcode),     32'(e.opc));
        chk("dr",            32'(bus.o_dr),         32'(e.dr));
        chk("jmp_cond",      32'(bus.o_jmp_cond),   32'(e.jc));
        chk("sr1_val",       bus.o_sr1_val,         e.s1);
        chk("sr2_val",       bus.o_sr2_val,         e.s2);
        chk("target_offset", bus.o_target_offset,   e.off);
        chk("pc",            bus.o_pc,              e.pc);
        chk("decode_err",    32'(bus.o_decode_err), 32'(e.err));
      end
    end
  end

  initial begin
    int guard;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    idle_inputs();

    // Writeback then read
    bus.i_wb_reg = 4'd3; bus.i_wb_val = 32'h1234;
    step();
    idle_inputs();
    issue(5'h01, 4'd4, 4'd3, 4'd3, 32'h100);
    step();

    // Forward priority, then without of1
    idle_inputs();
    issue(5'h01, 4'd6, 4'd5, 4'd0, 32'h104);
    bus.i_of1_reg = 4'd5; bus.i_of1_val = 32'hAAAA;
    bus.i_of2_reg = 4'd5; bus.i_of2_val = 32'hBBBB;
    bus.i_wb_reg  = 4'd5; bus.i_wb_val  = 32'hCCCC;
    step();
    bus.i_of1_reg = 4'd0;
    step();

    // Snoop during stall: r7 still holds 0
    idle_inputs();
    issue(5'h02, 4'd8, 4'd7, 4'd3, 32'h108);
    bus.i_jmp_cond = 4'hA; bus.i_imm = 32'h40;
    step();
    idle_inputs();
    bus.i_pipe_stall = 1'b1;
    issue(5'h03, 4'd9, 4'd1, 4'd2, 32'h10C);
    step(); step(); step();
    bus.i_of1_reg = 4'd7; bus.i_of1_val = 32'h55;
    step();

    // Flush over stall
    bus.i_of1_reg = 4'd0;
    bus.i_pipe_flush = 1'b1;
    step();

    // Immediate operand, then a stalled of1 aimed at r0
    idle_inputs();
    issue(5'h01, 4'd2, 4'd3, 4'd3, 32'h110);
    bus.i_imm_valid = 1'b1; bus.i_imm = 32'hFFFFFFFC;
    step();
    idle_inputs();
    bus.i_pipe_stall = 1'b1;
    bus.i_of1_reg = 4'd0; bus.i_of1_val = 32'h1111;
    step();

    // r0 write is ignored and r0 reads as zero
    idle_inputs();
    bus.i_wb_reg = 4'd0; bus.i_wb_val = 32'h99;
    issue(5'h01, 4'd1, 4'd0, 4'd0, 32'h114);
    step();
    idle_inputs();
    issue(5'h01, 4'd1, 4'd0, 4'd0, 32'h118);
    step();

    // Reset mid-operation after filling r1..r15, then read everything back
    for (int r = 1; r < 16; r++) begin
      idle_inputs();
      bus.i_wb_reg = 4'(r); bus.i_wb_val = 32'hA000_0000 | 32'(r);
      step();
    end
    idle_inputs();
    issue(5'h05, 4'd3, 4'd2, 4'd4, 32'h11C);
    bus.i_pipe_stall = 1'b1;
    reset = 1'b1;
    step();
    for (int r = 1; r < 16; r += 2) begin
      idle_inputs();
      issue(5'h01, 4'd1, 4'(r), 4'(r + 1), 32'h200 + 32'(r));
      step();
    end

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset            = ($urandom_range(0, 99) < 2);
      bus.i_pipe_flush = ($urandom_range(0, 99) < 8);
      bus.i_pipe_stall = ($urandom_range(0, 99) < 35);
      bus.i_opcode     = 5'($urandom_range(0, 31));
      bus.i_dr         = 4'($urandom_range(0, 15));
      bus.i_sr1        = 4'($urandom_range(0, 15));
      bus.i_sr2        = 4'($urandom_range(0, 15));
      bus.i_jmp_cond   = 4'($urandom_range(0, 15));
      bus.i_imm        = $urandom;
      bus.i_imm_valid  = ($urandom_range(0, 3) == 0);
      bus.i_pc         = $urandom;
      bus.i_decode_err = ($urandom_range(0, 15) == 0);
      bus.i_of1_reg    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.i_of1_val    = $urandom;
      bus.i_of2_reg    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.i_of2_val    = $urandom;
      bus.i_wb_reg     = 4'($urandom_range(0, 15));
      bus.i_wb_val     = $urandom;
      step();
    end

    idle_inputs();
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
